// File: rtl/repetition_check_correct_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : repetition_pkg
// Description : Shared helpers for the repetition check/correct unit: block
//               width calculation and the per-bit majority vote rule.
//               Optional feature macro used by this slice:
//               REPETITION_ERROR_COUNTER_EN (adds an error event counter).
// Revision    : 1.0 - initial release
// ============================================================================
package repetition_pkg;

    // Widest copy vector the majority helper accepts; callers zero-extend.
    localparam int MAX_REPETITION = 64;

    // Width of the redundant part of a block (everything except copy 0).
    function automatic int code_width(input int data_width, input int repetition);
        return (repetition - 1) * data_width;
    endfunction

    // Majority of the lowest 'repetition' bits of 'copies'. An exact tie
    // (only possible for even repetition) resolves to 'tie_bit', which the
    // caller sets to the received data bit so detect-only setups echo data.
    function automatic logic majority(input logic [MAX_REPETITION-1:0] copies,
                                      input int                        repetition,
                                      input logic                      tie_bit);
        int ones;
        ones = 0;
        for (int k = 0; k < MAX_REPETITION; k++) begin
            if ((k < repetition) && copies[k]) begin
                ones++;
            end
        end
        if (2 * ones > repetition) begin
            return 1'b1;
        end else if (2 * ones < repetition) begin
            return 1'b0;
        end
        return tie_bit;
    endfunction

endpackage : repetition_pkg
`default_nettype wire

// File: rtl/repetition_check_correct_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : repetition_check_correct_unit_if
// Description : Word-level bus of the repetition check/correct unit. The
//               master drives the received block, the slave returns the
//               registered check/correct results.
//               REPETITION_ERROR_COUNTER_EN adds err_count/err_count_clear.
// Revision    : 1.0 - initial release
// ============================================================================
interface repetition_check_correct_unit_if
    import repetition_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REPETITION = 3
);
    localparam int CODE_WIDTH = code_width(DATA_WIDTH, REPETITION);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [CODE_WIDTH-1:0] in_code;
    logic                  out_valid;
    logic                  out_error;
    logic [DATA_WIDTH-1:0] out_corrected_data;
    logic [DATA_WIDTH-1:0] out_mismatch_mask;
`ifdef REPETITION_ERROR_COUNTER_EN
    logic                  err_count_clear;
    logic [15:0]           err_count;
`endif

    modport master (
        output in_valid, in_data, in_code,
`ifdef REPETITION_ERROR_COUNTER_EN
        output err_count_clear,
        input  err_count,
`endif
        input  out_valid, out_error, out_corrected_data, out_mismatch_mask
    );

    modport slave (
        input  in_valid, in_data, in_code,
`ifdef REPETITION_ERROR_COUNTER_EN
        input  err_count_clear,
        output err_count,
`endif
        output out_valid, out_error, out_corrected_data, out_mismatch_mask
    );

endinterface : repetition_check_correct_unit_if
`default_nettype wire

// File: rtl/repetition_check_correct_unit_voter.sv
`default_nettype none
// ============================================================================
// Module      : repetition_majority_voter
// Description : Combinational vote for one bit position: majority of all
//               copies (tie -> copy 0) and a flag when any copy differs
//               from copy 0.
// Revision    : 1.0 - initial release
// ============================================================================
module repetition_majority_voter
    import repetition_pkg::*;
#(
    parameter int REPETITION = 3
) (
    input  wire logic [REPETITION-1:0] i_copies,
    output logic                       o_voted,
    output logic                       o_mismatch
);

    logic [MAX_REPETITION-1:0] w_padded;

    assign w_padded   = MAX_REPETITION'(i_copies);
    assign o_voted    = majority(w_padded, REPETITION, i_copies[0]);
    // Any copy unequal to copy 0 means the copies are not all identical.
    assign o_mismatch = |(i_copies ^ {REPETITION{i_copies[0]}});

endmodule : repetition_majority_voter
`default_nettype wire

// File: rtl/repetition_check_correct_unit.sv
`default_nettype none
// ============================================================================
// Module      : repetition_check_correct_unit
// Description : One-stage registered checker/corrector for repetition-coded
//               words. Flags copy disagreement per bit and outputs the
//               bitwise majority-voted data. Outputs hold while idle.
//               Optional: REPETITION_ERROR_COUNTER_EN adds a saturating
//               16-bit count of valid words that carried an error.
// Revision    : 1.0 - initial release
// ============================================================================
module repetition_check_correct_unit
    import repetition_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REPETITION = 3
) (
    input wire logic                clock,
    input wire logic                reset,
    repetition_check_correct_unit_if.slave bus
);

    localparam int CODE_WIDTH = code_width(DATA_WIDTH, REPETITION);

    if (REPETITION < 2) begin : g_bad_repetition
        $error("repetition_check_correct_unit: REPETITION must be at least 2");
    end
    if (REPETITION > MAX_REPETITION) begin : g_big_repetition
        $error("repetition_check_correct_unit: REPETITION exceeds MAX_REPETITION");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("repetition_check_correct_unit: DATA_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] w_voted;
    logic [DATA_WIDTH-1:0] w_mismatch;
    logic                  w_error;

    // Gather the same bit position from every copy and vote on it.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        logic [REPETITION-1:0] w_copies;

        assign w_copies[0] = bus.in_data[i];
        for (genvar k = 1; k < REPETITION; k++) begin : g_copy
            assign w_copies[k] = bus.in_code[(k-1)*DATA_WIDTH + i];
        end

        repetition_majority_voter #(
            .REPETITION (REPETITION)
        ) u_voter (
            .i_copies   (w_copies),
            .o_voted    (w_voted[i]),
            .o_mismatch (w_mismatch[i])
        );
    end

    assign w_error = |w_mismatch;

    logic                  r_valid;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_mask;

    // Result stage: valid tracks every cycle, results only load on valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_data  <= '0;
            r_mask  <= '0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_error <= w_error;
                r_data  <= w_voted;
                r_mask  <= w_mismatch;
            end
        end
    end

    assign bus.out_valid          = r_valid;
    assign bus.out_error          = r_error;
    assign bus.out_corrected_data = r_data;
    assign bus.out_mismatch_mask  = r_mask;

`ifdef REPETITION_ERROR_COUNTER_EN
    logic [15:0] r_err_count;

    // Error event counter: clear wins, otherwise count erroneous valid words
    // and stick at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_count <= 16'h0000;
        end else if (bus.err_count_clear) begin
            r_err_count <= 16'h0000;
        end else if (bus.in_valid && w_error && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'h0001;
        end
    end

    assign bus.err_count = r_err_count;
`endif

endmodule : repetition_check_correct_unit
`default_nettype wire

// File: tb/tb_repetition_check_correct_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_repetition_check_correct_unit
// Description : Self-checking bench for repetition_check_correct_unit
//               (DATA_WIDTH=8, REPETITION=3). A per-bit counting model
//               tracks expected outputs; a negedge process compares every
//               cycle; directed vectors pin literal values.
//               Honours REPETITION_ERROR_COUNTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_repetition_check_correct_unit;

    localparam int DW = 8;
    localparam int R  = 3;
    localparam int CW = (R - 1) * DW;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    always #5 clock = ~clock;

    repetition_check_correct_unit_if #(.DATA_WIDTH(DW), .REPETITION(R)) bus ();

    repetition_check_correct_unit #(
        .DATA_WIDTH (DW),
        .REPETITION (R)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Expected outputs, maintained by the model.
    logic          exp_valid = 1'b0;
    logic          exp_error = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic [DW-1:0] exp_mask  = '0;
    logic [15:0]   exp_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: block = {code, data}; copy k bit i is block[k*DW+i].
    task automatic model_word(input logic [DW-1:0] d, input logic [CW-1:0] c,
                              output logic e, output logic [DW-1:0] v, output logic [DW-1:0] m);
        logic [R*DW-1:0] blk;
        int ones;
        blk = {c, d};
        v = '0;
        m = '0;
        for (int i = 0; i < DW; i++) begin
            ones = 0;
            for (int k = 0; k < R; k++) begin
                if (blk[k*DW + i]) ones++;
                if (blk[k*DW + i] != blk[i]) m[i] = 1'b1;
            end
            if (2 * ones > R)      v[i] = 1'b1;
            else if (2 * ones < R) v[i] = 1'b0;
            else                   v[i] = blk[i];
        end
        e = |m;
    endtask

    always @(posedge clock or posedge reset) begin
        logic e;
        logic [DW-1:0] v, m;
        if (reset) begin
            exp_valid = 1'b0;
            exp_error = 1'b0;
            exp_data  = '0;
            exp_mask  = '0;
            exp_count = '0;
        end else begin
            model_word(bus.in_data, bus.in_code, e, v, m);
            exp_valid = bus.in_valid;
            if (bus.in_valid) begin
                exp_error = e;
                exp_data  = v;
                exp_mask  = m;
            end
`ifdef REPETITION_ERROR_COUNTER_EN
            if (bus.err_count_clear)                               exp_count = '0;
            else if (bus.in_valid && e && exp_count != 16'hFFFF)   exp_count = exp_count + 16'd1;
`endif
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clock) begin
        if (!done) begin
            check("cyc_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("cyc_error", 32'(bus.out_error), 32'(exp_error));
            check("cyc_data",  32'(bus.out_corrected_data), 32'(exp_data));
            check("cyc_mask",  32'(bus.out_mismatch_mask), 32'(exp_mask));
`ifdef REPETITION_ERROR_COUNTER_EN
            check("cyc_count", 32'(bus.err_count), 32'(exp_count));
`endif
        end
    end

    task automatic send(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
        @(negedge clock);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_code  = c;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic e,
                              input logic [DW-1:0] d, input logic [DW-1:0] m);
        check({name, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({name, "_error"}, 32'(bus.out_error), 32'(e));
        check({name, "_data"},  32'(bus.out_corrected_data), 32'(d));
        check({name, "_mask"},  32'(bus.out_mismatch_mask), 32'(m));
    endtask

    initial begin
        logic [DW-1:0]   b;
        logic [R*DW-1:0] blk;
        logic [R*DW-1:0] one;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_code  = '0;
`ifdef REPETITION_ERROR_COUNTER_EN
        bus.err_count_clear = 1'b0;
`endif
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        expect_out("reset", 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b0;

        // Directed literal vectors.
        send(1'b1, 8'hA5, 16'hA5A5); expect_out("clean_a5",   1'b1, 1'b0, 8'hA5, 8'h00);
        send(1'b1, 8'hA5, 16'h5A5A); expect_out("invert_a5",  1'b1, 1'b1, 8'h5A, 8'hFF);
        send(1'b1, 8'hA4, 16'hA5A5); expect_out("flip_d0",    1'b1, 1'b1, 8'hA5, 8'h01);
        send(1'b1, 8'hA5, 16'h25A5); expect_out("flip_c2b7",  1'b1, 1'b1, 8'hA5, 8'h80);
        send(1'b1, 8'h00, 16'h0100); expect_out("double_err", 1'b1, 1'b1, 8'h00, 8'h01);

        // Hold: idle cycle with garbage leaves results untouched.
        send(1'b1, 8'hC3, 16'hC3C3); expect_out("pre_hold",   1'b1, 1'b0, 8'hC3, 8'h00);
        send(1'b0, 8'h3C, 16'h1234); expect_out("hold",       1'b0, 1'b0, 8'hC3, 8'h00);

        // Reset with a word in flight, then a fresh word.
        send(1'b1, 8'h3C, 16'h3C3C); expect_out("pre_reset",  1'b1, 1'b0, 8'h3C, 8'h00);
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_data = 8'h81; bus.in_code = 16'h8180;
        #2 reset = 1'b1;
        #1 expect_out("async_reset", 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.in_code = 16'h5A5B;
        @(posedge clock); #1;
        expect_out("post_reset", 1'b1, 1'b1, 8'h5A, 8'h01);

        // Sweeps: clean, inverted, every single-bit flip.
        for (int x = 0; x < 256; x++) begin
            b = 8'(x);
            send(1'b1, b, {b, b});
            check("sweep_clean_err",  32'(bus.out_error), 32'd0);
            check("sweep_clean_data", 32'(bus.out_corrected_data), 32'(b));
            send(1'b1, b, {~b, ~b});
            check("sweep_inv_err",    32'(bus.out_error), 32'd1);
            for (int p = 0; p < R * DW; p++) begin
                one = '0;
                one[p] = 1'b1;
                blk = {b, b, b} ^ one;
                send(1'b1, blk[DW-1:0], blk[R*DW-1:DW]);
                check("sweep_flip_data", 32'(bus.out_corrected_data), 32'(b));
                check("sweep_flip_mask", 32'(bus.out_mismatch_mask), 32'(1) << (p % DW));
            end
        end

`ifdef REPETITION_ERROR_COUNTER_EN
        @(negedge clock); bus.err_count_clear = 1'b1; bus.in_valid = 1'b0;
        @(negedge clock); bus.err_count_clear = 1'b0;
        send(1'b1, 8'h11, 16'h1110);
        send(1'b1, 8'h22, 16'h2222);
        send(1'b1, 8'h33, 16'h3033);
        send(1'b1, 8'h44, 16'h4444);
        send(1'b1, 8'h55, 16'hD555);
        check("count_three", 32'(bus.err_count), 32'd3);
        @(negedge clock); bus.err_count_clear = 1'b1;
        send(1'b1, 8'h01, 16'h0000);
        check("count_clear", 32'(bus.err_count), 32'd0);
        @(negedge clock); bus.err_count_clear = 1'b0;
        for (int n = 0; n < 65540; n++) send(1'b1, 8'h01, 16'h0000);
        check("count_sat", 32'(bus.err_count), 32'hFFFF);
`endif

        send(1'b0, 8'h00, 16'h0000);
        @(negedge clock);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_repetition_check_correct_unit
`default_nettype wire

// File: doc/repetition_check_correct_unit.md
Name: repetition_check_correct_unit

Overview:
- Registered checker/corrector for repetition-coded words; sits on the receive side of a link or storage path protected by a repetition encoder.
- Takes a data word plus its (REPETITION-1) redundant copies, flags any disagreement between copies, and outputs the bitwise majority-voted data.
- One pipeline stage.

Parameters:
- DATA_WIDTH, 8, width of one data copy; must be at least 1.
- REPETITION, 3, total number of copies including the data; must be at least 2 (elaboration error otherwise).
- CODE_WIDTH, (REPETITION-1)*DATA_WIDTH, derived localparam; not overridable.

Ports:
- clock  in  1  sampling clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present this cycle.
- in_data  in  DATA_WIDTH  copy 0 (received data).
- in_code  in  CODE_WIDTH  copies 1..REPETITION-1; copy k occupies bits [k*DATA_WIDTH-1 : (k-1)*DATA_WIDTH].
- out_valid  out  1  registered in_valid.
- out_error  out  1  any copy disagrees with any other copy.
- out_corrected_data  out  DATA_WIDTH  per-bit majority of all copies.
- out_mismatch_mask  out  DATA_WIDTH  bit i set when copies disagree at bit position i.

Behaviour:
- Block view: block = {in_code, in_data}, i.e. copy 0 in the LSBs; encoder convention is code = data replicated REPETITION-1 times.
- Mismatch: mask[i] = OR over k of (copy_k[i] XOR copy_0[i]); error = OR-reduce(mask).
- Majority: per bit, count the ones across the REPETITION copies.
  - count > REPETITION/2 gives 1; count < REPETITION/2 gives 0.
  - Exact tie (even REPETITION) resolves to copy_0[i].
- With REPETITION=2 the block detects only; corrected data equals in_data.
- Latency: exactly 1 cycle. Outputs update on the rising edge when in_valid=1. out_valid=in_valid registered every cycle.
- When in_valid=0, error, data and mask registers hold their previous values; out_valid drops to 0.
- Reset (asynchronous assert, synchronous-safe deassert):
  - out_valid=0, out_error=0, out_corrected_data=0, out_mismatch_mask=0.
  - Reset mid-stream discards the in-flight word; the first valid word after deassert appears 1 cycle after sampling.
- Correction guarantee: any error pattern with fewer than REPETITION/2 corrupted copies per bit position is corrected.
- Beyond that, out_error is still asserted whenever copies disagree, but the corrected data may be wrong. No uncorrectable flag.
- All-copies-flipped-identically at a bit is undetectable by construction and is not flagged.

Optional Feature:
- Macro REPETITION_ERROR_COUNTER_EN.
- Defined:
  - Adds output err_count [15:0] and input err_count_clear (1 bit).
  - Counter increments on each cycle with in_valid=1 and a detected error, saturating at 0xFFFF.
  - clear has priority over increment; counter resets to 0.
- Undefined: neither port exists, no counter logic.

Decomposition:
- Package repetition_pkg:
  - localparam function code_width(data_width, repetition).
  - Function majority(bit vector of REPETITION copies, tie bit) returning 1 bit.
- One combinational sub-module, repetition_majority_voter: instantiated per bit via generate.
  - Inputs: the REPETITION copy bits.
  - Outputs: voted bit and mismatch bit.
- The top level holds the registers and the optional counter.

Test Plan (DATA_WIDTH=8, REPETITION=3):
- Clean words: in_data=0xA5, in_code=0xA5A5, valid -> next cycle out_error=0, out_corrected_data=0xA5, mask=0x00. Sweep all 256 values, always error=0 and data echoed.
- Inverted copies: in_data=0xA5, in_code=0x5A5A -> error=1, corrected=0x5A, mask=0xFF. Sweep all 256 values, error always 1.
- Single-bit flips at each of the 24 block positions for every data value, e.g. in_data=0xA4, in_code=0xA5A5 or in_data=0xA5, in_code=0x25A5 -> error=1, corrected=0xA5, mask has exactly the flipped position set.
- Double error at same position: original data 0x01, apply in_data=0x00, in_code=0x0100 -> error=1, corrected=0x00 (documented miscorrection), mask=0x01.
- Hold/valid:
  - Drive a word with in_valid=1, then in_valid=0 with garbage inputs -> out_valid=0, other outputs unchanged.
  - Assert reset between two valid words -> all outputs 0 immediately, next word correct 1 cycle after sampling.
- With REPETITION_ERROR_COUNTER_EN:
  - 3 erroneous plus 2 clean valid words -> err_count=3.
  - Clear concurrent with an error word -> err_count=0.
  - Preload to saturation -> stays 0xFFFF.
